// File: rtl/mux_pkg.sv
// Shared definitions for the scanned/registered channel multiplexer:
// mode encodings, default sizing and the round-robin next-channel search.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 8;
  localparam int DEF_DIV      = 50000;

  // Upper bound on channel count; the search works on a mask of this width.
  localparam int MAX_CHANNELS = 16;

  // Next enabled channel strictly after cur, searching upward and wrapping
  // from channels-1 to 0. A cur at or beyond the last channel (possible after
  // an out-of-range manual select) restarts the search at channel 0. When cur
  // is the only enabled channel the search lands back on cur. With an empty
  // mask cur is returned unchanged.
  function automatic int next_enabled(input int cur,
                                      input logic [MAX_CHANNELS-1:0] mask,
                                      input int channels);
    int   cand;
    int   result;
    logic found;
    cand   = (cur + 1 >= channels) ? 0 : cur + 1;
    result = cur;
    found  = 1'b0;
    for (int k = 0; k < MAX_CHANNELS; k++) begin
      if ((k < channels) && !found) begin
        if (mask[cand[3:0]]) begin
          result = cand;
          found  = 1'b1;
        end
        cand = (cand + 1 >= channels) ? 0 : cand + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: counts 0..DIV-1 and flags the terminal count as a
// one-cycle tick. hold freezes the count (and suppresses the tick); clear
// forces the count to 0 and suppresses the tick.
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int                CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = !clear && !hold && (count_q == LAST);

  // Next count: clear wins, hold freezes, otherwise wrap at the terminal count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!hold) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual select and
// round-robin scan modes. All outputs are registered.
// Optional feature: define MUX_SCAN_BLANK_EN to insert one blanking cycle
// (o=0, o_valid=0, o_sel already at the new channel) after each scan
// advance that changes channel.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = 3,
  parameter int DIV      = DEF_DIV
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic                      hold,
  output logic [WIDTH-1:0]          o,
  output logic [SEL_W-1:0]          o_sel,
  output logic                      o_valid,
  output logic                      o_step
);

  logic                 tick;
  logic [SEL_W-1:0]     cur_q,   cur_d;
  logic [WIDTH-1:0]     o_q,     o_d;
  logic                 valid_q, valid_d;
  logic                 step_q,  step_d;
  logic                 blank;
  logic [MAX_CHANNELS-1:0] mask_ext;
  logic [WIDTH-1:0]     cur_data;
  logic                 cur_in_range;
  logic                 cur_enabled;
  logic                 show;

  // Unpack the channel bus into an indexable array.
  logic [WIDTH-1:0] ch_data [CHANNELS];
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign ch_data[gi] = data_in[gi*WIDTH +: WIDTH];
  end

  // Prescaler is parked at 0 throughout manual mode so scan always starts
  // a full DIV period after the switch.
  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (mode == MODE_MANUAL),
    .hold  (hold),
    .tick  (tick)
  );

  // Zero-extend the mask to the width the shared search function expects.
  always_comb begin
    mask_ext                 = '0;
    mask_ext[CHANNELS-1:0]   = ch_mask;
  end

  // Channel selection: follow sel in manual mode, advance on ticks in scan.
  always_comb begin
    cur_d  = cur_q;
    step_d = 1'b0;
    blank  = 1'b0;
    if (mode == MODE_MANUAL) begin
      cur_d = sel;
    end else if (tick && (ch_mask != '0)) begin
      cur_d  = SEL_W'(next_enabled(int'(cur_q), mask_ext, CHANNELS));
      step_d = 1'b1;
`ifdef MUX_SCAN_BLANK_EN
      blank  = (cur_d != cur_q);
`endif
    end
  end

  // Output data: live data of the channel about to be driven, gated by range,
  // mask (scan only) and the optional blanking cycle.
  always_comb begin
    cur_data     = '0;
    cur_in_range = 1'b0;
    cur_enabled  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur_d == SEL_W'(k)) begin
        cur_data     = ch_data[k];
        cur_in_range = 1'b1;
        cur_enabled  = ch_mask[k];
      end
    end
    show    = cur_in_range && ((mode == MODE_MANUAL) || cur_enabled) && !blank;
    o_d     = show ? cur_data : '0;
    valid_d = show;
  end

  // Output and channel registers; reset overrides every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= '0;
      o_q     <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      step_q  <= step_d;
    end
  end

  assign o       = o_q;
  assign o_sel   = cur_q;
  assign o_valid = valid_q;
  assign o_step  = step_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: the stimulus process runs a behavioural
// model and queues the expected outputs; an independent monitor pops one
// entry per clock and compares it with the DUT.
module tb_mux_scan_n;

  localparam int W  = 8;
  localparam int CH = 6;
  localparam int SW = 3;
  localparam int DV = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*W-1:0]   data_in;
  logic              mode;
  logic [SW-1:0]     sel;
  logic [CH-1:0]     ch_mask;
  logic              hold;
  logic [W-1:0]      o;
  logic [SW-1:0]     o_sel;
  logic              o_valid;
  logic              o_step;

  logic [W-1:0]      dat [CH];

  typedef struct {
    logic [W-1:0]  o;
    logic [SW-1:0] sel;
    logic          valid;
    logic          step;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference state: current channel and prescaler count.
  int   m_cur = 0;
  int   m_pc  = 0;

  mux_scan_n #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .SEL_W    (SW),
    .DIV      (DV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .mode    (mode),
    .sel     (sel),
    .ch_mask (ch_mask),
    .hold    (hold),
    .o       (o),
    .o_sel   (o_sel),
    .o_valid (o_valid),
    .o_step  (o_step)
  );

  always #5 clk = ~clk;

  // Next enabled channel after cur, upward with wrap.
  function automatic int next_en(input int cur, input logic [CH-1:0] mask);
    int c;
    for (int i = 0; i < CH; i++) begin
      c = (cur >= CH - 1) ? i : (cur + 1 + i) % CH;
      if (mask[c]) return c;
    end
    return cur;
  endfunction

  // Apply the current inputs for one clock and queue the expected outputs.
  task automatic cycle();
    exp_t e;
    bit   tick;
    bit   blank;
    bit   en;
    int   nc;
    for (int k = 0; k < CH; k++) data_in[k*W +: W] = dat[k];
    e.step = 1'b0;
    if (rst) begin
      m_cur   = 0;
      m_pc    = 0;
      e.o     = '0;
      e.valid = 1'b0;
    end else if (mode == 1'b0) begin
      m_cur   = int'(sel);
      m_pc    = 0;
      en      = (m_cur < CH);
      e.o     = en ? dat[m_cur] : '0;
      e.valid = en;
    end else begin
      tick  = !hold && (m_pc == DV - 1);
      blank = 1'b0;
      if (!hold) m_pc = (m_pc + 1) % DV;
      if (tick && (ch_mask != '0)) begin
        nc     = next_en(m_cur, ch_mask);
        e.step = 1'b1;
`ifdef MUX_SCAN_BLANK_EN
        blank  = (nc != m_cur);
`endif
        m_cur  = nc;
      end
      en      = (m_cur < CH) && ch_mask[m_cur] && !blank;
      e.o     = en ? dat[m_cur] : '0;
      e.valid = en;
    end
    e.sel = SW'(m_cur);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one expected entry per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (o !== e.o) begin
          miscompares++;
          $display("FAIL o vec %0d: got %02h expected %02h", vectors, o, e.o);
        end
        if (o_sel !== e.sel) begin
          miscompares++;
          $display("FAIL o_sel vec %0d: got %0d expected %0d", vectors, o_sel, e.sel);
        end
        if (o_valid !== e.valid) begin
          miscompares++;
          $display("FAIL o_valid vec %0d: got %0b expected %0b", vectors, o_valid, e.valid);
        end
        if (o_step !== e.step) begin
          miscompares++;
          $display("FAIL o_step vec %0d: got %0b expected %0b", vectors, o_step, e.step);
        end
        $display("vec %0d: o=%02h o_sel=%0d o_valid=%0b o_step=%0b", vectors, o, o_sel, o_valid, o_step);
      end
    end
  end

  // Stimulus.
  initial begin
    rst     = 1'b1;
    mode    = 1'b0;
    sel     = '0;
    ch_mask = '0;
    hold    = 1'b0;
    for (int k = 0; k < CH; k++) dat[k] = 8'h10 + W'(k);
    data_in = '0;
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b0;

    // Manual select, including out-of-range selects.
    sel = 3'd5; cycle();
    sel = 3'd7; cycle();
    sel = 3'd6; cycle();
    sel = 3'd2; cycle();
    sel = 3'd0; cycle();

    // Scan over channels 0,2,5 from channel 0.
    mode    = 1'b1;
    ch_mask = 6'b100101;
    repeat (20) cycle();

    // Empty mask, then a single enabled channel.
    ch_mask = '0;
    repeat (20) cycle();
    ch_mask = 6'b001000;
    repeat (8) cycle();

    // Hold mid-count while the current channel's data changes.
    ch_mask = 6'b011010;
    repeat (6) cycle();
    hold = 1'b1;
    dat[m_cur < CH ? m_cur : 0] = 8'hAA;
    repeat (10) cycle();
    hold = 1'b0;
    repeat (10) cycle();

    // Reset in the middle of a scan.
    rst = 1'b1; cycle();
    rst = 1'b0;

    // Manual -> scan handover with two enabled channels.
    mode = 1'b0; sel = 3'd1; cycle();
    mode = 1'b1; ch_mask = 6'b000011;
    repeat (14) cycle();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      sel  = SW'($urandom_range(0, 7));
      if ($urandom_range(0, 14) == 0) ch_mask = CH'($urandom);
      hold = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 149) == 0);
      dat[$urandom_range(0, CH - 1)] = W'($urandom);
      cycle();
    end
    rst = 1'b0;

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
